// File: rtl/result_drain.sv
// Double-buffered drain for systolic_array results. It captures a whole tile of accumulators
// into one of two shadow banks and streams the tile out one beat per handshake.
module result_drain #(
  parameter int N_PE   = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8,
  localparam int IDX_W = (N_PE > 1) ? $clog2(N_PE) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   capture,
  input  logic [N_PE*DATA_W-1:0] c_flat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last,
  output logic                   busy,
  output logic                   overrun,
  input  logic                   clr_overrun,
  output logic [CNT_W-1:0]       tiles_done
);

  logic [1:0]       bank_full_reg;
  logic [1:0]       bank_full_next;
  logic             wr_bank_reg;
  logic             rd_bank_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             overrun_reg;
  logic [CNT_W-1:0] tiles_done_reg;

  logic [DATA_W-1:0] bank_mem [2][N_PE];
  logic [DATA_W-1:0] c_word [N_PE];

  logic valid;
  logic fire;
  logic last_beat;
  logic final_fire;
  logic cap_accept;
  logic cap_reject;

  generate
    for (genvar gi = 0; gi < N_PE; gi++) begin : g_unpack
      assign c_word[gi] = c_flat[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign valid      = bank_full_reg[rd_bank_reg];
  assign fire       = valid && out_ready;
  assign last_beat  = (idx_reg == IDX_W'(N_PE - 1));
  assign final_fire = fire && last_beat;

  // With both banks full, wr_bank equals rd_bank, so a final beat frees exactly the bank
  // the capture is about to write.
  assign cap_accept = capture && (!bank_full_reg[wr_bank_reg] || final_fire);
  assign cap_reject = capture && !cap_accept;

  always_comb begin
    bank_full_next = bank_full_reg;
    if (final_fire) bank_full_next[rd_bank_reg] = 1'b0;
    if (cap_accept) bank_full_next[wr_bank_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_full_reg  <= 2'b00;
      wr_bank_reg    <= 1'b0;
      rd_bank_reg    <= 1'b0;
      idx_reg        <= '0;
      overrun_reg    <= 1'b0;
      tiles_done_reg <= '0;
    end else begin
      bank_full_reg <= bank_full_next;
      if (cap_accept) wr_bank_reg <= ~wr_bank_reg;
      if (fire) begin
        if (last_beat) begin
          idx_reg        <= '0;
          rd_bank_reg    <= ~rd_bank_reg;
          tiles_done_reg <= tiles_done_reg + 1'b1;
        end else begin
          idx_reg <= idx_reg + 1'b1;
        end
      end
      if (cap_reject)       overrun_reg <= 1'b1;
      else if (clr_overrun) overrun_reg <= 1'b0;
    end
  end

  // Bank storage carries no reset; bank_full alone decides whether its contents are meaningful.
  always_ff @(posedge clk) begin
    if (cap_accept) begin
      for (int i = 0; i < N_PE; i++) begin
        bank_mem[wr_bank_reg][i] <= c_word[i];
      end
    end
  end

  assign out_valid  = valid;
  assign out_data   = valid ? bank_mem[rd_bank_reg][idx_reg] : '0;
  assign out_idx    = idx_reg;
  assign out_last   = valid && last_beat;
  assign busy       = |bank_full_reg;
  assign overrun    = overrun_reg;
  assign tiles_done = tiles_done_reg;

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: directed scenarios plus random traffic, checked against a
// queue-of-tiles reference model.
module tb_result_drain;
  localparam int N_PE   = 16;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;
  localparam int TW     = N_PE * DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              capture = 1'b0;
  logic [TW-1:0]     c_flat = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_idx;
  logic              out_last;
  logic              busy;
  logic              overrun;
  logic              clr_overrun = 1'b0;
  logic [CNT_W-1:0]  tiles_done;

  result_drain #(.N_PE(N_PE), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .capture(capture), .c_flat(c_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .overrun(overrun),
    .clr_overrun(clr_overrun), .tiles_done(tiles_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO of at most two whole tiles, beat position, sticky flag, counter.
  logic [TW-1:0] mq[$];
  int            pos = 0;
  bit            m_ovr = 1'b0;
  int            m_done = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit v;
    v = (mq.size() > 0);
    chk("out_valid", 64'(out_valid), 64'(v));
    chk("out_idx", 64'(out_idx), 64'(pos));
    chk("out_last", 64'(out_last), 64'(v && pos == N_PE - 1));
    chk("busy", 64'(busy), 64'(v));
    chk("overrun", 64'(overrun), 64'(m_ovr));
    chk("tiles_done", 64'(tiles_done), 64'(m_done % 256));
    if (v) chk("out_data", 64'(out_data), 64'(mq[0][pos*DATA_W +: DATA_W]));
  endtask

  // One clock: drive inputs, check current outputs, advance the model over the edge.
  task automatic step(input bit cap, input logic [TW-1:0] data, input bit rdy, input bit clr);
    bit fire;
    bit rejected;
    capture = cap; c_flat = data; out_ready = rdy; clr_overrun = clr;
    check_outputs();
    rejected = 1'b0;
    fire = (mq.size() > 0) && rdy;
    if (fire) begin
      if (pos == N_PE - 1) begin
        pos = 0;
        void'(mq.pop_front());
        m_done++;
        $display("tile drained, tiles_done=%0d", m_done % 256);
      end else begin
        pos++;
      end
    end
    if (cap) begin
      if (mq.size() < 2) mq.push_back(data);
      else rejected = 1'b1;
    end
    if (clr) m_ovr = 1'b0;
    if (rejected) m_ovr = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0);
  endtask

  function automatic logic [TW-1:0] fill(input logic [DATA_W-1:0] w);
    logic [TW-1:0] t;
    for (int k = 0; k < N_PE; k++) t[k*DATA_W +: DATA_W] = w;
    return t;
  endfunction

  function automatic logic [TW-1:0] rand_tile();
    logic [TW-1:0] t;
    for (int k = 0; k < N_PE; k++) t[k*DATA_W +: DATA_W] = $urandom;
    return t;
  endfunction

  initial begin
    logic [TW-1:0] t;
    int base;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 64'(out_data), 64'(0));
    check_outputs();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: ramp tile 1..16, ready held high
    for (int k = 0; k < N_PE; k++) t[k*DATA_W +: DATA_W] = DATA_W'(k + 1);
    step(1'b1, t, 1'b1, 1'b0);
    idle(N_PE + 2, 1'b1);
    chk("t1_done", 64'(tiles_done), 64'(1));
    chk("t1_busy", 64'(busy), 64'(0));

    // 2: same tile, ready toggling
    step(1'b1, t, 1'b1, 1'b0);
    for (int i = 0; i < 2 * N_PE + 2; i++) step(1'b0, '0, (i % 2) == 1, 1'b0);

    // 3: two signed tiles back to back, no bubble
    step(1'b1, fill(32'hFFFF_FFF6), 1'b1, 1'b0);
    step(1'b1, fill(32'h7FFF_FFFF), 1'b1, 1'b0);
    idle(2 * N_PE + 2, 1'b1);
    chk("t3_done", 64'(tiles_done), 64'(4));

    // 4: third capture dropped while stalled, then cleared
    step(1'b1, rand_tile(), 1'b0, 1'b0);
    step(1'b1, rand_tile(), 1'b0, 1'b0);
    step(1'b1, rand_tile(), 1'b0, 1'b0);
    chk("t4_ovr", 64'(overrun), 64'(1));
    idle(3, 1'b0);
    step(1'b1, rand_tile(), 1'b0, 1'b1);
    idle(2 * N_PE + 2, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("t4_clr", 64'(overrun), 64'(0));

    // 5: capture coincides with the final beat while both banks are full
    base = m_done;
    step(1'b1, rand_tile(), 1'b0, 1'b0);
    step(1'b1, rand_tile(), 1'b0, 1'b0);
    idle(N_PE - 1, 1'b1);
    step(1'b1, rand_tile(), 1'b1, 1'b0);
    chk("t5_ovr", 64'(overrun), 64'(0));
    idle(2 * N_PE + 2, 1'b1);
    chk("t5_done", 64'(tiles_done), 64'((base + 3) % 256));

    // 6: asynchronous reset at beat 7
    step(1'b1, rand_tile(), 1'b1, 1'b0);
    idle(7, 1'b1);
    chk("t6_idx7", 64'(out_idx), 64'(7));
    rst = 1'b0;
    #1;
    mq.delete(); pos = 0; m_ovr = 1'b0; m_done = 0;
    chk("t6_data", 64'(out_data), 64'(0));
    check_outputs();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, rand_tile(), 1'b1, 1'b0);
    idle(N_PE + 2, 1'b1);
    chk("t6_done", 64'(tiles_done), 64'(1));

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 6) == 0, rand_tile(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0);
    end
    idle(2 * N_PE + 4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
